// File: rtl/t2mi_cfg_pkg.sv
// t2mi_cfg_pkg
//   Shared definitions for the T2-MI configuration sequencer:
//   register map addresses, commit codes, power-up configuration values,
//   the sequencer state enumeration and the shadow validity check.
`timescale 1ns/1ps

package t2mi_cfg_pkg;

  // Register map (write-only)
  localparam logic [7:0] ADDR_TS_TYPE     = 8'h00;
  localparam logic [7:0] ADDR_SFLEN_B0    = 8'h01;
  localparam logic [7:0] ADDR_SFLEN_B1    = 8'h02;
  localparam logic [7:0] ADDR_SFLEN_B2    = 8'h03;
  localparam logic [7:0] ADDR_SFLEN_B3    = 8'h04;
  localparam logic [7:0] ADDR_T2MI_PID_LO = 8'h05;
  localparam logic [7:0] ADDR_T2MI_PID_HI = 8'h06;
  localparam logic [7:0] ADDR_STREAM_ID   = 8'h07;
  localparam logic [7:0] ADDR_PMT_PID_LO  = 8'h08;
  localparam logic [7:0] ADDR_PMT_PID_HI  = 8'h09;
  localparam logic [7:0] ADDR_COMMIT      = 8'h10;
  localparam logic [7:0] ADDR_ERR_CLR     = 8'h11;

  // Data values written to ADDR_COMMIT
  localparam logic [7:0] COMMIT_AT_SF = 8'h01;
  localparam logic [7:0] COMMIT_NOW   = 8'h02;

  // Configuration loaded at reset, into both shadow and active banks
  localparam logic [1:0]  CFG_TS_TYPE_DEF    = 2'd0;
  localparam logic [26:0] CFG_SFRAME_LEN_DEF = 27'd100000;
  localparam logic [12:0] CFG_T2MI_PID_DEF   = 13'h1000;
  localparam logic [2:0]  CFG_STREAM_ID_DEF  = 3'd0;
  localparam logic [12:0] CFG_PMT_PID_DEF    = 13'h0020;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SF,
    PULSE
  } seq_state_t;

  // Timestamp type 3 is undefined and a zero-length superframe would
  // stall the packer, so neither may ever reach the active bank.
  function automatic logic cfg_is_valid(input logic [1:0] ts_type,
                                        input logic [26:0] sf_len);
    return (ts_type != 2'd3) && (sf_len != 27'd0);
  endfunction

endpackage

// File: rtl/t2mi_cfg_shadow.sv
// t2mi_cfg_shadow
//   Decodes SPI register writes into the shadow configuration bank and
//   flags whether the shadow contents are fit to be committed.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   spi_data/address    write data and register address from the SPI slave
//   spi_ena             one-cycle write strobe
//   sh_*                shadow bank contents (registered)
//   sh_valid            shadow bank passes validation
//   commit_at_sf        this cycle is a valid-code boundary-commit write
//   commit_now          this cycle is a valid-code immediate-commit write
//   err_clear           this cycle is a write to the error-clear register
`timescale 1ns/1ps

module t2mi_cfg_shadow
  import t2mi_cfg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  spi_data,
  input  logic [7:0]  spi_address,
  input  logic        spi_ena,
  output logic [1:0]  sh_timestamp_type,
  output logic [26:0] sh_sframe_len,
  output logic [12:0] sh_t2mi_pid,
  output logic [2:0]  sh_stream_id,
  output logic [12:0] sh_pmt_pid,
  output logic        sh_valid,
  output logic        commit_at_sf,
  output logic        commit_now,
  output logic        err_clear
);

  // Shadow bank: one byte lane per register address, written whatever
  // state the sequencer is in.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_timestamp_type <= CFG_TS_TYPE_DEF;
      sh_sframe_len     <= CFG_SFRAME_LEN_DEF;
      sh_t2mi_pid       <= CFG_T2MI_PID_DEF;
      sh_stream_id      <= CFG_STREAM_ID_DEF;
      sh_pmt_pid        <= CFG_PMT_PID_DEF;
    end else if (spi_ena) begin
      case (spi_address)
        ADDR_TS_TYPE:     sh_timestamp_type     <= spi_data[1:0];
        ADDR_SFLEN_B0:    sh_sframe_len[7:0]    <= spi_data;
        ADDR_SFLEN_B1:    sh_sframe_len[15:8]   <= spi_data;
        ADDR_SFLEN_B2:    sh_sframe_len[23:16]  <= spi_data;
        ADDR_SFLEN_B3:    sh_sframe_len[26:24]  <= spi_data[2:0];
        ADDR_T2MI_PID_LO: sh_t2mi_pid[7:0]      <= spi_data;
        ADDR_T2MI_PID_HI: sh_t2mi_pid[12:8]     <= spi_data[4:0];
        ADDR_STREAM_ID:   sh_stream_id          <= spi_data[2:0];
        ADDR_PMT_PID_LO:  sh_pmt_pid[7:0]       <= spi_data;
        ADDR_PMT_PID_HI:  sh_pmt_pid[12:8]      <= spi_data[4:0];
        default: ;
      endcase
    end
  end

  // Validity is judged on the registered shadow, i.e. the pre-write value,
  // which is exactly what a load in this cycle would copy.
  assign sh_valid     = cfg_is_valid(sh_timestamp_type, sh_sframe_len);
  assign commit_at_sf = spi_ena && (spi_address == ADDR_COMMIT) && (spi_data == COMMIT_AT_SF);
  assign commit_now   = spi_ena && (spi_address == ADDR_COMMIT) && (spi_data == COMMIT_NOW);
  assign err_clear    = spi_ena && (spi_address == ADDR_ERR_CLR);

endmodule

// File: rtl/t2mi_cfg_sequencer.sv
// t2mi_cfg_sequencer
//   Owns the T2-MI packer's run-time configuration. Commits the shadow bank
//   to the active outputs either at the next superframe boundary or at once
//   under an INNER_RST pulse, with a timeout fallback for missing boundaries.
// Ports:
//   CLK, RST              clock, synchronous active-high reset
//   SPI_DATA/ADDRESS/ENA  register write interface from the SPI slave
//   SF_BOUNDARY           superframe start pulse from the packer
//   timestamp_type, sframe_len, t2mi_pid, stream_id, pmt_pid
//                         active configuration to the packer
//   INNER_RST             packer reset pulse, RST_CYCLES long
//   BUSY                  commit pending or in progress
//   CFG_ERR               sticky error (invalid commit or boundary timeout)
`timescale 1ns/1ps

module t2mi_cfg_sequencer
  import t2mi_cfg_pkg::*;
#(
  parameter int unsigned RST_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 2**24
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  SPI_DATA,
  input  logic [7:0]  SPI_ADDRESS,
  input  logic        SPI_ENA,
  input  logic        SF_BOUNDARY,
  output logic [1:0]  timestamp_type,
  output logic [26:0] sframe_len,
  output logic [12:0] t2mi_pid,
  output logic [2:0]  stream_id,
  output logic [12:0] pmt_pid,
  output logic        INNER_RST,
  output logic        BUSY,
  output logic        CFG_ERR
);

  localparam logic [31:0] RST_LAST     = 32'(RST_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [1:0]  sh_timestamp_type;
  logic [26:0] sh_sframe_len;
  logic [12:0] sh_t2mi_pid;
  logic [2:0]  sh_stream_id;
  logic [12:0] sh_pmt_pid;
  logic        sh_valid;
  logic        commit_at_sf;
  logic        commit_now;
  logic        err_clear;

  seq_state_t  state_q, state_d;
  logic [31:0] cnt_q;
  logic        cnt_clr;
  logic        load;
  logic        err_set;

  t2mi_cfg_shadow u_shadow (
    .clk               (CLK),
    .rst               (RST),
    .spi_data          (SPI_DATA),
    .spi_address       (SPI_ADDRESS),
    .spi_ena           (SPI_ENA),
    .sh_timestamp_type (sh_timestamp_type),
    .sh_sframe_len     (sh_sframe_len),
    .sh_t2mi_pid       (sh_t2mi_pid),
    .sh_stream_id      (sh_stream_id),
    .sh_pmt_pid        (sh_pmt_pid),
    .sh_valid          (sh_valid),
    .commit_at_sf      (commit_at_sf),
    .commit_now        (commit_now),
    .err_clear         (err_clear)
  );

  // Commit requests are only honoured in IDLE; elsewhere they are dropped
  // silently. A boundary wins over a timeout landing in the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    load    = 1'b0;
    err_set = 1'b0;
    case (state_q)
      IDLE: begin
        if ((commit_now || commit_at_sf) && !sh_valid) begin
          err_set = 1'b1;
        end else if (commit_now) begin
          load    = 1'b1;
          cnt_clr = 1'b1;
          state_d = PULSE;
        end else if (commit_at_sf) begin
          cnt_clr = 1'b1;
          state_d = WAIT_SF;
        end
      end
      WAIT_SF: begin
        if (SF_BOUNDARY) begin
          load    = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          err_set = 1'b1;
          load    = 1'b1;
          cnt_clr = 1'b1;
          state_d = PULSE;
        end
      end
      PULSE: begin
        if (cnt_q == RST_LAST) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register and the shared wait/pulse counter, zeroed on entry to
  // WAIT_SF or PULSE and frozen while idle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (cnt_clr) begin
        cnt_q <= '0;
      end else if (state_q != IDLE) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

  // Active configuration bank, copied from the shadow on a load.
  always_ff @(posedge CLK) begin
    if (RST) begin
      timestamp_type <= CFG_TS_TYPE_DEF;
      sframe_len     <= CFG_SFRAME_LEN_DEF;
      t2mi_pid       <= CFG_T2MI_PID_DEF;
      stream_id      <= CFG_STREAM_ID_DEF;
      pmt_pid        <= CFG_PMT_PID_DEF;
    end else if (load) begin
      timestamp_type <= sh_timestamp_type;
      sframe_len     <= sh_sframe_len;
      t2mi_pid       <= sh_t2mi_pid;
      stream_id      <= sh_stream_id;
      pmt_pid        <= sh_pmt_pid;
    end
  end

  // Sticky error flag; a new error outranks a clear in the same cycle so
  // that no error event is lost.
  always_ff @(posedge CLK) begin
    if (RST) begin
      CFG_ERR <= 1'b0;
    end else if (err_set) begin
      CFG_ERR <= 1'b1;
    end else if (err_clear) begin
      CFG_ERR <= 1'b0;
    end
  end

  assign INNER_RST = (state_q == PULSE);
  assign BUSY      = (state_q != IDLE);

endmodule

// File: tb/tb_t2mi_cfg_sequencer.sv
// tb_t2mi_cfg_sequencer
//   Self-checking bench for t2mi_cfg_sequencer. Each stimulus cycle pushes
//   the outputs expected after the next clock edge onto a scoreboard queue;
//   after the edge the entry is popped and every output is compared.
`timescale 1ns/1ps

module tb_t2mi_cfg_sequencer;

  localparam int unsigned RST_CYC = 16;
  localparam int unsigned TO_CYC  = 100;
  localparam logic [26:0] DEF_LEN = 27'd100000;

  logic        BOARD_CLK = 1'b0;
  logic        rst;
  logic [7:0]  spi_data;
  logic [7:0]  spi_address;
  logic        spi_ena;
  logic        sf_boundary;
  logic [1:0]  timestamp_type;
  logic [26:0] sframe_len;
  logic [12:0] t2mi_pid;
  logic [2:0]  stream_id;
  logic [12:0] pmt_pid;
  logic        inner_rst;
  logic        busy;
  logic        cfg_err;

  typedef struct {
    logic [1:0]  ts;
    logic [26:0] len;
    logic [12:0] tpid;
    logic [2:0]  sid;
    logic [12:0] ppid;
    logic        irst;
    logic        busy;
    logic        err;
  } snap_t;

  snap_t exp_now;
  snap_t sb_q[$];
  int    vec_count  = 0;
  int    miss_count = 0;
  string phase      = "reset";

  t2mi_cfg_sequencer #(
    .RST_CYCLES     (RST_CYC),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .CLK            (BOARD_CLK),
    .RST            (rst),
    .SPI_DATA       (spi_data),
    .SPI_ADDRESS    (spi_address),
    .SPI_ENA        (spi_ena),
    .SF_BOUNDARY    (sf_boundary),
    .timestamp_type (timestamp_type),
    .sframe_len     (sframe_len),
    .t2mi_pid       (t2mi_pid),
    .stream_id      (stream_id),
    .pmt_pid        (pmt_pid),
    .INNER_RST      (inner_rst),
    .BUSY           (busy),
    .CFG_ERR        (cfg_err)
  );

  always #5 BOARD_CLK = ~BOARD_CLK;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vec_count++;
    if (obs !== expv) begin
      miss_count++;
      $display("[TB] FAIL %s/%s: got 0x%0h, expected 0x%0h", phase, tag, obs, expv);
    end
  endtask

  task automatic setDefaults();
    exp_now.ts   = 2'd0;
    exp_now.len  = DEF_LEN;
    exp_now.tpid = 13'h1000;
    exp_now.sid  = 3'd0;
    exp_now.ppid = 13'h0020;
    exp_now.irst = 1'b0;
    exp_now.busy = 1'b0;
    exp_now.err  = 1'b0;
  endtask

  // Drive one cycle of inputs, then check outputs just after the edge.
  task automatic applyStimulus(input logic r, input logic ena, input logic [7:0] addr,
                               input logic [7:0] data, input logic sf);
    snap_t got;
    rst         = r;
    spi_ena     = ena;
    spi_address = addr;
    spi_data    = data;
    sf_boundary = sf;
    sb_q.push_back(exp_now);
    @(posedge BOARD_CLK);
    #1;
    got = sb_q.pop_front();
    checkOutput("timestamp_type", 32'(timestamp_type), 32'(got.ts));
    checkOutput("sframe_len",     32'(sframe_len),     32'(got.len));
    checkOutput("t2mi_pid",       32'(t2mi_pid),       32'(got.tpid));
    checkOutput("stream_id",      32'(stream_id),      32'(got.sid));
    checkOutput("pmt_pid",        32'(pmt_pid),        32'(got.ppid));
    checkOutput("INNER_RST",      32'(inner_rst),      32'(got.irst));
    checkOutput("BUSY",           32'(busy),           32'(got.busy));
    checkOutput("CFG_ERR",        32'(cfg_err),        32'(got.err));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic spiWrite(input logic [7:0] addr, input logic [7:0] data);
    applyStimulus(1'b0, 1'b1, addr, data, 1'b0);
  endtask

  initial begin
    rst = 1'b1; spi_ena = 1'b0; spi_address = 8'h00; spi_data = 8'h00; sf_boundary = 1'b0;
    setDefaults();

    phase = "reset";
    applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    idle(3);

    // Boundary commit; a boundary coincident with the commit write is not taken,
    // and a shadow write coincident with the load does not leak into it.
    phase = "boundary";
    spiWrite(8'h05, 8'hBC);
    spiWrite(8'h06, 8'h0A);
    exp_now.busy = 1'b1;
    applyStimulus(1'b0, 1'b1, 8'h10, 8'h01, 1'b1);
    idle(49);
    exp_now.tpid = 13'h0ABC;
    exp_now.busy = 1'b0;
    applyStimulus(1'b0, 1'b1, 8'h07, 8'h05, 1'b1);
    idle(2);

    // Immediate commit; the stream id written during the previous load lands now.
    phase = "immediate";
    spiWrite(8'h01, 8'h67);
    spiWrite(8'h02, 8'h45);
    spiWrite(8'h03, 8'h23);
    spiWrite(8'h04, 8'h01);
    exp_now.len  = 27'h1234567;
    exp_now.sid  = 3'd5;
    exp_now.irst = 1'b1;
    exp_now.busy = 1'b1;
    spiWrite(8'h10, 8'h02);
    idle(RST_CYC - 1);
    exp_now.irst = 1'b0;
    exp_now.busy = 1'b0;
    idle(3);

    phase = "invalid";
    spiWrite(8'h00, 8'h03);
    exp_now.err = 1'b1;
    spiWrite(8'h10, 8'h01);
    idle(3);
    spiWrite(8'h10, 8'h03);
    exp_now.err = 1'b0;
    spiWrite(8'h11, 8'h00);
    idle(1);

    phase = "timeout";
    spiWrite(8'h00, 8'h01);
    exp_now.busy = 1'b1;
    spiWrite(8'h10, 8'h01);
    idle(TO_CYC - 1);
    exp_now.ts   = 2'd1;
    exp_now.irst = 1'b1;
    exp_now.err  = 1'b1;
    idle(1);
    idle(RST_CYC - 1);
    exp_now.irst = 1'b0;
    exp_now.busy = 1'b0;
    idle(2);
    exp_now.err = 1'b0;
    spiWrite(8'h11, 8'hAA);

    // Reset during the fifth pulse cycle, with an ignored commit before it.
    phase = "rst_mid";
    spiWrite(8'h08, 8'h34);
    spiWrite(8'h09, 8'h12);
    exp_now.ppid = 13'h1234;
    exp_now.irst = 1'b1;
    exp_now.busy = 1'b1;
    spiWrite(8'h10, 8'h02);
    spiWrite(8'h08, 8'h55);
    spiWrite(8'h10, 8'h02);
    idle(2);
    setDefaults();
    applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    idle(RST_CYC + 4);

    // Shadow was reset too: a fresh commit reloads defaults under a pulse.
    phase = "post_rst";
    exp_now.irst = 1'b1;
    exp_now.busy = 1'b1;
    spiWrite(8'h10, 8'h02);
    idle(RST_CYC - 1);
    exp_now.irst = 1'b0;
    exp_now.busy = 1'b0;
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule

// File: doc/t2mi_cfg_sequencer.md
# t2mi_cfg_sequencer

Controller that owns the T2-MI packer's run-time configuration. It decodes SPI register writes into a shadow bank, validates them, and commits the shadow bank to the active configuration outputs that feed the packer. A commit happens either hitlessly at the next superframe boundary or immediately under a controlled inner reset pulse. It sits between the SPI slave and the packer, and replaces ad-hoc decoding of configuration registers.

## Interface
Parameters:
- RST_CYCLES, 16: length of the INNER_RST pulse, in cycles (≥1).
- TIMEOUT_CYCLES, 2^24: maximum wait for SF_BOUNDARY before falling back to an immediate commit.

Ports:
- CLK  in  1  single clock (DCLK domain); all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- SPI_DATA  in  8  write data from SPI slave.
- SPI_ADDRESS  in  8  register address.
- SPI_ENA  in  1  one-cycle write strobe.
- SF_BOUNDARY  in  1  one-cycle pulse at superframe start, from the packer.
- timestamp_type  out  2  active config: 0 null, 1 relative, 2 absolute.
- sframe_len  out  27  active superframe period, in subsecond units.
- t2mi_pid  out  13  active T2-MI PID.
- stream_id  out  3  active stream id.
- pmt_pid  out  13  active PMT PID.
- INNER_RST  out  1  packer reset pulse.
- BUSY  out  1  commit pending or in progress.
- CFG_ERR  out  1  sticky error flag.

## Operation
Register map (write-only; unmapped addresses ignored):
- 0x00: timestamp_type[1:0].
- 0x01–0x04: sframe_len, LSB first; 0x04 uses bits [2:0].
- 0x05/0x06: t2mi_pid low byte / bits [12:8].
- 0x07: stream_id[2:0].
- 0x08/0x09: pmt_pid low byte / bits [12:8].
- 0x10: commit. 0x01 = commit at boundary; 0x02 = immediate commit. Other values are ignored.
- 0x11: any write clears CFG_ERR.

Shadow writes:
- Accepted in every state.
- The shadow value sampled at the load cycle is the one committed.

Validation, evaluated on the commit write:
- Shadow is invalid if timestamp_type==3 or sframe_len==0.
- Invalid commit: rejected, CFG_ERR set, state unchanged.

FSM states:
- IDLE:
  - valid 0x01 → WAIT_SF, timeout counter cleared.
  - valid 0x02 → load active from shadow, go to PULSE.
- WAIT_SF:
  - SF_BOUNDARY → load active, go to IDLE.
  - Timeout counter reaches TIMEOUT_CYCLES-1 → set CFG_ERR, load active, go to PULSE.
- PULSE:
  - INNER_RST high; counter runs RST_CYCLES cycles, then go to IDLE.
- Commit writes arriving while not in IDLE are ignored. They neither queue nor set CFG_ERR.
- BUSY = (state != IDLE).

## Timing
- Reset values:
  - timestamp_type=0, sframe_len=CFG_SFRAME_LEN_DEF, t2mi_pid=0x1000, stream_id=0, pmt_pid=0x0020.
  - INNER_RST=0, BUSY=0, CFG_ERR=0, state IDLE.
  - Shadow bank resets to the same defaults.
- SPI write: shadow register updated the cycle after SPI_ENA.
- Boundary commit:
  - Active outputs change the cycle after SF_BOUNDARY is sampled high in WAIT_SF.
  - BUSY falls in the same cycle.
  - An SF_BOUNDARY in the same cycle as the 0x01 write is not taken; the commit waits for the next boundary.
- Immediate commit:
  - The cycle after the 0x02 write, active outputs update, INNER_RST rises, and BUSY rises.
  - INNER_RST stays high exactly RST_CYCLES cycles; BUSY falls with it.
- Simultaneous SPI shadow write and load in the same cycle: the load uses the pre-write shadow value.
- Timeout: INNER_RST rises TIMEOUT_CYCLES cycles after the cycle WAIT_SF is entered.
- RST mid-operation: everything returns to reset values on the next edge.
  - An INNER_RST pulse in progress is cut off.
  - A pending commit is discarded.
- Outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package t2mi_cfg_pkg:
  - register address constants;
  - commit codes 0x01/0x02;
  - default config values (CFG_SFRAME_LEN_DEF, PID defaults);
  - FSM state enumeration (IDLE, WAIT_SF, PULSE).
- One natural sub-module, t2mi_cfg_shadow:
  - contains the address decode and shadow register bank, plus the validity flag;
  - the sequencer keeps the FSM, counters, active registers and error flag.

## Test plan
- Reset, no writes → defaults on outputs (t2mi_pid=0x1000, pmt_pid=0x0020); INNER_RST=0; BUSY=0.
- Write t2mi_pid=0x0ABC, then 0x10←0x01, SF_BOUNDARY 50 cycles later → t2mi_pid stays 0x1000 until the cycle after the boundary, then becomes 0x0ABC; INNER_RST never asserted.
- Write sframe_len=0x1234567, then 0x10←0x02 (RST_CYCLES=16) → sframe_len updates next cycle; INNER_RST high exactly 16 cycles; BUSY mirrors it.
- Write timestamp_type=3, then commit 0x01 → CFG_ERR=1, BUSY=0, active timestamp_type unchanged; 0x11 write clears CFG_ERR.
- Commit 0x01 with no SF_BOUNDARY (TIMEOUT_CYCLES=100) → after 100 cycles CFG_ERR=1, INNER_RST pulses, active config loaded.
- Assert RST during cycle 5 of an INNER_RST pulse → next cycle INNER_RST=0, BUSY=0, outputs back to defaults; a second 0x02 commit issued while BUSY is ignored.
